// File: rtl/burst_sram_arbiter.sv
// -----------------------------------------------------------------------------
// burst_sram_arbiter
//
// Two-requester round-robin arbiter and burst sequencer for a single-port
// burst SRAM. A requester posts a burst command (direction, start address,
// length). The block grants one requester at a time. It then issues one SRAM
// beat per cycle, with an address that increments and wraps around the array.
// During a burst it returns per-beat write acknowledges or read data. A
// one-cycle done pulse marks the end of each burst.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req[1:0]          burst request per requester (sampled only when idle)
//   req_we[1:0]       per requester: 1 = write burst, 0 = read burst
//   req_addr          per-requester start address, slice i = [i*ADDR_W +: ADDR_W]
//   req_len           per-requester burst length, 0 encodes 2^LEN_W beats
//   wdata             per-requester current write beat data
//   gnt[1:0]          one-hot pulse during the first beat of an accepted burst
//   wr_ack[1:0]       one-hot pulse per write beat consumed
//   rd_valid/rd_data/rd_id  read beat data and its owner, one cycle after the beat
//   done/done_id      one-cycle completion pulse and owner of the burst
//   busy              high whenever a burst is in progress
//   mem_*             SRAM interface; mem_rdata is valid one cycle after a read beat
// -----------------------------------------------------------------------------
module burst_sram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*LEN_W-1:0]  req_len,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          wr_ack,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_id,
  output logic                done,
  output logic                done_id,
  output logic                busy,
  output logic                mem_cs,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               owner_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_q;
  logic               last_owner_q;
  logic               rd_valid_q;
  logic               rd_id_q;

  logic               sel_valid;
  logic               sel;
  logic               last_beat;
  logic               in_burst;
  logic [1:0]         owner_oh;

  // Arbitration. On a tie the requester that was not served last wins.
  // A lone request selects its own index.
  assign sel_valid = |req;
  assign sel       = (req == 2'b11) ? ~last_owner_q : req[1];

  // len = 0 means 2^LEN_W beats. Subtracting 1 modulo 2^LEN_W yields the
  // index of the final beat for every encoding, including len = 0.
  assign last_beat = (beat_q == LEN_W'(len_q - 1'b1));

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (sel_valid) state_d = S_BURST;
      S_BURST: if (last_beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the values present before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      last_owner_q <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_id_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      // The SRAM returns read data one cycle after the beat, so the valid
      // flag and its owner are delayed to line up with mem_rdata.
      rd_valid_q <= (state_q == S_BURST) && !we_q;
      rd_id_q    <= owner_q;
      unique case (state_q)
        S_IDLE: begin
          if (sel_valid) begin
            owner_q      <= sel;
            we_q         <= req_we[sel];
            addr_q       <= req_addr[sel*ADDR_W +: ADDR_W];
            len_q        <= req_len[sel*LEN_W +: LEN_W];
            last_owner_q <= sel;
            beat_q       <= '0;
          end
        end
        S_BURST: beat_q <= beat_q + 1'b1;
        default: ;
      endcase
    end
  end

  // All SRAM controls, handshakes and status are decoded from registers only.
  // The only exceptions are the data paths that the interface defines as
  // combinational: the write-data mux and the read-data pass-through.
  assign in_burst = (state_q == S_BURST);
  assign owner_oh = {owner_q, ~owner_q};

  assign mem_cs    = in_burst;
  assign mem_we    = in_burst && we_q;
  // The address sum truncates to ADDR_W bits, so it wraps instead of saturating.
  assign mem_addr  = in_burst ? ADDR_W'(addr_q + ADDR_W'(beat_q)) : '0;
  assign mem_wdata = mem_we ? wdata[owner_q*DATA_W +: DATA_W] : '0;

  assign gnt      = (in_burst && beat_q == '0) ? owner_oh : 2'b00;
  assign wr_ack   = mem_we ? owner_oh : 2'b00;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? mem_rdata : '0;
  assign rd_id    = rd_valid_q && rd_id_q;
  assign done     = (state_q == S_DONE);
  assign done_id  = done && owner_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_burst_sram_arbiter.sv
module tb_burst_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, req_we;
  logic [7:0]  req_addr, req_len;
  logic [15:0] wdata;
  logic [1:0]  gnt, wr_ack;
  logic        rd_valid, rd_id, done, done_id, busy, mem_cs, mem_we;
  logic [7:0]  rd_data, mem_wdata, mem_rdata;
  logic [3:0]  mem_addr;

  int errors = 0;
  int checks = 0;

  // Memory seen by the DUT, and the bench's own record of what it should hold.
  logic [7:0] sram [16];
  logic [7:0] ref_mem [16];
  logic [7:0] bdata [16];
  int         ref_last;

  burst_sram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .wdata(wdata), .gnt(gnt), .wr_ack(wr_ack),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id), .done(done),
    .done_id(done_id), .busy(busy), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_wr_ack"}, wr_ack, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_id"}, rd_id, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_done_id"}, done_id, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_cs"}, mem_cs, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // Runs one burst from a lone requester. The caller must be at cycle 0,
  // i.e. just after a clock edge with the DUT idle. Beat data comes from
  // bdata. Expected outputs follow from the cycle timeline: beats occupy
  // cycles 1..L, read data appears in cycles 2..L+1, and done pulses in L+1.
  task automatic run_burst(input string tag, input int who, input bit we,
                           input int addr, input int len);
    int n;
    n = (len == 0) ? 16 : len;
    req_we[who]          = we;
    req_addr[who*4 +: 4] = 4'(addr);
    req_len[who*4 +: 4]  = 4'(len);
    wdata[who*8 +: 8]    = bdata[0];
    req[who]             = 1'b1;
    @(negedge clk);
    check({tag, "_pre_busy"}, busy, 0);
    check({tag, "_pre_gnt"}, gnt, 0);
    @(posedge clk); #1;
    for (int c = 1; c <= n + 1; c++) begin
      if (we && c <= n) wdata[who*8 +: 8] = bdata[c-1];
      @(negedge clk);
      check({tag, "_gnt"}, gnt, (c == 1) ? (1 << who) : 0);
      if (c == 1) req[who] = 1'b0;
      check({tag, "_mem_cs"}, mem_cs, c <= n);
      check({tag, "_mem_we"}, mem_we, we && c <= n);
      check({tag, "_mem_addr"}, mem_addr, (c <= n) ? (addr + c - 1) % 16 : 0);
      check({tag, "_mem_wdata"}, mem_wdata, (we && c <= n) ? bdata[c-1] : 0);
      check({tag, "_wr_ack"}, wr_ack, (we && c <= n) ? (1 << who) : 0);
      check({tag, "_rd_valid"}, rd_valid, !we && c >= 2);
      check({tag, "_rd_data"}, rd_data, (!we && c >= 2) ? ref_mem[(addr + c - 2) % 16] : 0);
      check({tag, "_rd_id"}, rd_id, (!we && c >= 2) ? who : 0);
      check({tag, "_done"}, done, c == n + 1);
      check({tag, "_done_id"}, done_id, (c == n + 1) ? who : 0);
      check({tag, "_busy"}, busy, 1);
      if (we && c <= n) ref_mem[(addr + c - 1) % 16] = bdata[c-1];
      @(posedge clk); #1;
    end
    ref_last = who;
  endtask

  initial begin
    int first, owner, phase, who, addr;
    req = '0; req_we = '0; req_addr = '0; req_len = '0; wdata = '0;
    rst_n = 1'b0;
    ref_last = 1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill the whole array with a 16-beat (len = 0) write.
    for (int i = 0; i < 16; i++) bdata[i] = 8'($urandom);
    run_burst("fill_len0", 1, 1'b1, 0, 0);

    // Single write, then read it back from the other requester.
    for (int i = 0; i < 4; i++) bdata[i] = 8'hA0 + 8'(i);
    run_burst("wr_single", 0, 1'b1, 3, 4);
    run_burst("rd_single", 1, 1'b0, 3, 4);
    check("rd_single_ref", ref_mem[5], 8'hA2);

    // Address wrap from 15 to 0; address 0 must hold the third beat.
    for (int i = 0; i < 3; i++) bdata[i] = 8'($urandom);
    run_burst("wrap_wr", 0, 1'b1, 14, 3);
    check("wrap_ref", ref_mem[0], bdata[2]);
    run_burst("wrap_rd", 1, 1'b0, 0, 1);

    // Length 0 read: 16 beats, done in cycle 17.
    run_burst("len0_rd", 0, 1'b0, 0, 0);

    // Round robin: both requests held. Each 2-beat burst is accept, 2 beats,
    // done, one idle cycle, so grants fall every 4 cycles and alternate.
    req_we = 2'b00;
    req_len = {4'd2, 4'd2};
    req_addr = 8'($urandom);
    req = 2'b11;
    first = 1 - ref_last;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      phase = (c - 1) % 4;
      owner = first ^ (((c - 1) / 4) & 1);
      check("rr_gnt", gnt, (phase == 0) ? (1 << owner) : 0);
      check("rr_done", done, phase == 2);
      check("rr_done_id", done_id, (phase == 2) ? owner : 0);
      check("rr_busy", busy, phase != 3);
      if (c == 16) req = 2'b00;
    end
    ref_last = 1 - first;
    @(posedge clk); #1;

    // Reset during beat 2 of an 8-beat write by requester 1.
    for (int i = 0; i < 8; i++) bdata[i] = 8'($urandom);
    addr = int'($urandom_range(0, 15));
    req_we[1] = 1'b1;
    req_addr[7:4] = 4'(addr);
    req_len[7:4] = 4'd8;
    req[1] = 1'b1;
    @(posedge clk); #1;
    req[1] = 1'b0;
    wdata[15:8] = bdata[0];
    @(posedge clk); #1;
    wdata[15:8] = bdata[1];
    @(posedge clk); #1;
    wdata[15:8] = bdata[2];
    ref_mem[addr % 16] = bdata[0];
    ref_mem[(addr + 1) % 16] = bdata[1];
    #1;
    check("rst_mid_busy_before", busy, 1);
    check("rst_mid_addr_before", mem_addr, (addr + 2) % 16);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    req_we = 2'b00;
    req_len = {4'd1, 4'd1};
    req = 2'b11;
    repeat (2) begin
      @(negedge clk);
      check_all_zero("rst_hold");
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_after_gnt", gnt, 2'b01);
    req = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_after_done", done, 1);
    check("rst_after_done_id", done_id, 0);
    @(posedge clk); #1;
    ref_last = 0;

    // Check the SRAM contents that survived the aborted burst.
    run_burst("rst_readback", 1, 1'b0, addr, 2);

    // Random bursts against the reference memory.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 16; i++) bdata[i] = 8'($urandom);
      who = int'($urandom_range(0, 1));
      run_burst("rand", who, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
